// File: rtl/uart_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_defs_pkg                                              |
// | Description : Shared UART receive-side definitions.                      |
// |               - Reset defaults for the baud divisor and FIFO depth.      |
// |               - Helpers that size FIFO pointers and occupancy counts.    |
// |               - uart_rx state encodings, shared with benches.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_defs_pkg;

  // Reset-time defaults that top-level parameters inherit.
  localparam int unsigned UART_DEFAULT_DIV = 27;
  localparam int unsigned UART_FIFO_DEPTH  = 8;

  // Number of bits that index a FIFO of 'depth' entries.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit so that 'depth' itself can be represented.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // State encoding of the uart_rx serial datapath.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_e;

endpackage : uart_defs_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                               |
// | Description : Synchronous first-word-fall-through FIFO for received      |
// |               bytes. A push into a full FIFO is accepted only when a pop |
// |               happens in the same cycle.                                 |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               push, din         - write request and data                 |
// |               pop               - read request (ignored when empty)      |
// |               dout              - head entry (valid when !empty)         |
// |               count, count_next - registered occupancy / next value      |
// |               full, empty       - status decoded from count              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_fifo
  import uart_defs_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              din,
  input  logic                          pop,
  output logic [WIDTH-1:0]              dout,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic [cnt_width(DEPTH)-1:0]   count_next,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full       = (count_q == c_full_count);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign count_next = count_d;
  assign dout       = mem_q[rd_ptr_q];

  // A pop frees the slot the push needs, so full + push + pop is legal.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q] = din;
      // Pointer width equals log2(DEPTH), so the wrap is implicit.
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: contents of an empty FIFO are don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_ctrl                                               |
// | Description : UART receive controller. Generates the 16x oversampling   |
// |               enable for uart_rx, buffers received bytes in a FWFT FIFO, |
// |               and reports occupancy, a sticky overrun flag and an        |
// |               optional level interrupt.                                  |
// | Config      : define UART_RX_IRQ_EN to build the threshold interrupt;    |
// |               otherwise irq is tied low and irq_level is ignored.        |
// | Ports       : clk, rst           - clock, synchronous active-high reset  |
// |               enable             - receiver enable, low stops ticks      |
// |               div_we, div_in     - baud divisor write                    |
// |               uart_tick_16x      - one-cycle pacing pulse to uart_rx     |
// |               rx_ready, rx_data  - byte-complete strobe and byte         |
// |               rd_en              - pop request                           |
// |               rd_data, rd_valid  - FIFO head and not-empty               |
// |               rx_count           - occupancy                             |
// |               overrun, overrun_clr - sticky drop flag and its clear      |
// |               irq_level, irq     - interrupt threshold and interrupt     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_ctrl
  import uart_defs_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int unsigned FIFO_DEPTH  = UART_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               div_we,
  input  logic [DIV_WIDTH-1:0]               div_in,
  output logic                               uart_tick_16x,
  input  logic                               rx_ready,
  input  logic [7:0]                         rx_data,
  input  logic                               rd_en,
  output logic [7:0]                         rd_data,
  output logic                               rd_valid,
  output logic [cnt_width(FIFO_DEPTH)-1:0]   rx_count,
  output logic                               overrun,
  input  logic                               overrun_clr,
  input  logic [cnt_width(FIFO_DEPTH)-1:0]   irq_level,
  output logic                               irq
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] c_rst_div  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] c_rst_bcnt =
    (DEFAULT_DIV == 0) ? '0 : DIV_WIDTH'(DEFAULT_DIV - 1);

  logic [DIV_WIDTH-1:0] div_q,  div_d;
  logic [DIV_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                 overrun_q, overrun_d;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [CW-1:0]        w_count_next;

  // ---------------------------------------------------------------------
  // Baud counter
  // ---------------------------------------------------------------------
  // The tick is decoded from the counter so that div==1 yields a tick on
  // every cycle. A divisor write suppresses the tick in its own cycle.
  assign uart_tick_16x = !rst && enable && !div_we &&
                         (div_q != '0) && (bcnt_q == '0);

  always_comb begin
    div_d  = div_q;
    bcnt_d = bcnt_q;
    if (div_we) begin
      div_d  = div_in;
      bcnt_d = (div_in == '0) ? '0 : div_in - 1'b1;
    end else if (!enable || (bcnt_q == '0)) begin
      // Idle reload keeps the first tick after enable rise one full period
      // away; the same expression handles the natural wrap and div==0.
      bcnt_d = (div_q == '0) ? '0 : div_q - 1'b1;
    end else begin
      bcnt_d = bcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= c_rst_div;
      bcnt_q <= c_rst_bcnt;
    end else begin
      div_q  <= div_d;
      bcnt_q <= bcnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Receive buffer
  // ---------------------------------------------------------------------
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rx_ready),
    .din        (rx_data),
    .pop        (rd_en),
    .dout       (rd_data),
    .count      (rx_count),
    .count_next (w_count_next),
    .full       (w_full),
    .empty      (w_empty)
  );

  assign rd_valid = !w_empty;

  // ---------------------------------------------------------------------
  // Overrun flag
  // ---------------------------------------------------------------------
  // A full FIFO is never empty, so any rd_en while full is a real pop and
  // frees room for the incoming byte.
  assign w_drop = rx_ready && w_full && !rd_en;

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    // Setting takes priority so a drop is never lost to a concurrent clear.
    if (w_drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

  // ---------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------
`ifdef UART_RX_IRQ_EN
  logic irq_q, irq_d;

  // Evaluated on next-state values so irq moves on the same edge as
  // rx_count and overrun.
  always_comb begin
    irq_d = ((w_count_next >= irq_level) && (irq_level != '0)) || overrun_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic w_unused_irq;
  assign w_unused_irq = ^{irq_level, w_count_next};
  assign irq          = 1'b0;
`endif

endmodule : uart_rx_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_ctrl                                            |
// | Description : Directed self-checking bench for uart_rx_ctrl: baud tick   |
// |               generation, FIFO push/pop, overrun, full+pop, interrupt   |
// |               threshold (UART_RX_IRQ_EN) and mid-traffic reset.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_ctrl;

  localparam int unsigned DIV_WIDTH   = 16;
  localparam int unsigned DEFAULT_DIV = 4;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_IRQ_EN
  localparam logic c_irq_on = 1'b1;
`else
  localparam logic c_irq_on = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 div_we;
  logic [DIV_WIDTH-1:0] div_in;
  logic                 uart_tick_16x;
  logic                 rx_ready;
  logic [7:0]           rx_data;
  logic                 rd_en;
  logic [7:0]           rd_data;
  logic                 rd_valid;
  logic [CW-1:0]        rx_count;
  logic                 overrun;
  logic                 overrun_clr;
  logic [CW-1:0]        irq_level;
  logic                 irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .div_we        (div_we),
    .div_in        (div_in),
    .uart_tick_16x (uart_tick_16x),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rx_count      (rx_count),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .irq_level     (irq_level),
    .irq           (irq)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    step();
    rx_ready = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if (uart_tick_16x !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", uart_tick_16x); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++;
    if (rx_count !== '0) begin n_fail++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    #1;
    // div=4 after reset: tick on the 4th, 8th and 12th cycle after release.
    for (int i = 1; i <= 12; i++) begin
      n_checks++;
      if (uart_tick_16x !== ((i % 4) == 0)) begin
        n_fail++;
        $display("FAIL reset_tick_cycle%0d: got %b want %b", i, uart_tick_16x, ((i % 4) == 0));
      end
      step();
    end
  endtask

  task automatic test_divisor();
    int ticks;
    // Writing div=0 stops the ticks entirely.
    div_we = 1'b1;
    div_in = '0;
    #1;
    n_checks++;
    if (uart_tick_16x !== 1'b0) begin n_fail++; $display("FAIL div_we_cycle_tick: got %b want 0", uart_tick_16x); end
    step();
    div_we = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (uart_tick_16x === 1'b1) ticks++;
      step();
    end
    n_checks++;
    if (ticks !== 0) begin n_fail++; $display("FAIL div0_ticks: got %0d want 0", ticks); end
    // div=1: a tick on every cycle.
    div_we = 1'b1;
    div_in = 16'd1;
    step();
    div_we = 1'b0;
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (uart_tick_16x === 1'b1) ticks++;
      step();
    end
    n_checks++;
    if (ticks !== 5) begin n_fail++; $display("FAIL div1_ticks: got %0d want 5", ticks); end
    // enable low: no ticks.
    enable = 1'b0;
    ticks  = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (uart_tick_16x === 1'b1) ticks++;
      step();
    end
    n_checks++;
    if (ticks !== 0) begin n_fail++; $display("FAIL disabled_ticks: got %0d want 0", ticks); end
    // Back to div=4 while disabled; first tick on the 4th enabled cycle.
    div_we = 1'b1;
    div_in = 16'd4;
    step();
    div_we = 1'b0;
    enable = 1'b1;
    #1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (uart_tick_16x !== ((i % 4) == 0)) begin
        n_fail++;
        $display("FAIL enable_tick_cycle%0d: got %b want %b", i, uart_tick_16x, ((i % 4) == 0));
      end
      step();
    end
  endtask

  task automatic test_single_byte();
    push_byte(8'hA5);
    n_checks++;
    if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid: got %b want 1", rd_valid); end
    n_checks++;
    if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_rd_data: got %h want a5", rd_data); end
    n_checks++;
    if (rx_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", rx_count); end
    pop_one();
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", rd_valid); end
    // Pop on empty is ignored.
    pop_one();
    n_checks++;
    if (rx_count !== 4'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d want 0", rx_count); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    n_checks++;
    if (rx_count !== 4'd8 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_state: got count %0d ovr %b want 8 0", rx_count, overrun);
    end
    push_byte(8'h08);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    n_checks++;
    if (rx_count !== 4'd8) begin n_fail++; $display("FAIL overrun_count: got %0d want 8", rx_count); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL overrun_pop%0d: got %h want %h", i, rd_data, 8'(i)); end
      pop_one();
    end
    n_checks++;
    if (rd_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL drained_state: got valid %b ovr %b want 0 1", rd_valid, overrun);
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b want 0", overrun); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [8];
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    rx_ready = 1'b1;
    rx_data  = 8'h55;
    rd_en    = 1'b1;
    step();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_overrun: got %b want 0", overrun); end
    n_checks++;
    if (rx_count !== 4'd8) begin n_fail++; $display("FAIL fullpop_count: got %0d want 8", rx_count); end
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rd_data !== exp[i]) begin n_fail++; $display("FAIL fullpop_pop%0d: got %h want %h", i, rd_data, exp[i]); end
      pop_one();
    end
    // Set wins over a simultaneous clear.
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
    rx_ready    = 1'b1;
    rx_data     = 8'hEE;
    overrun_clr = 1'b1;
    step();
    rx_ready    = 1'b0;
    overrun_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b want 1", overrun); end
    for (int i = 0; i < 8; i++) pop_one();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
  endtask

  task automatic test_irq();
    irq_level = 4'd3;
    push_byte(8'h01);
    push_byte(8'h02);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_below: got %b want 0", irq); end
    push_byte(8'h03);
    n_checks++;
    if (irq !== c_irq_on) begin n_fail++; $display("FAIL irq_at_level: got %b want %b", irq, c_irq_on); end
    pop_one();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop: got %b want 0", irq); end
    irq_level = 4'd0;
    push_byte(8'h04);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_level0: got %b want 0", irq); end
    for (int i = 0; i < 3; i++) pop_one();
    irq_level = 4'd3;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) push_byte(8'h20 + 8'(i));
    for (int i = 0; i < 3; i++) pop_one();
    n_checks++;
    if (rx_count !== 4'd5 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL premid_state: got count %0d ovr %b want 5 1", rx_count, overrun);
    end
    n_checks++;
    if (irq !== c_irq_on) begin n_fail++; $display("FAIL premid_irq: got %b want %b", irq, c_irq_on); end
    div_we = 1'b1;
    div_in = 16'd9;
    step();
    div_we = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || rx_count !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_fifo: got valid %b count %0d want 0 0", rd_valid, rx_count);
    end
    n_checks++;
    if (overrun !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: got ovr %b irq %b want 0 0", overrun, irq);
    end
    // Divisor returns to its reset value of 4.
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (uart_tick_16x !== (i == 4)) begin
        n_fail++;
        $display("FAIL mid_reset_tick%0d: got %b want %b", i, uart_tick_16x, (i == 4));
      end
      step();
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    div_we      = 1'b0;
    div_in      = '0;
    rx_ready    = 1'b0;
    rx_data     = '0;
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    irq_level   = 4'd3;
    test_reset();
    test_divisor();
    test_single_byte();
    test_overrun();
    test_full_pop();
    test_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_ctrl
`default_nettype wire
